// File: rtl/csd_serializer.sv
// csd_serializer: loads one W-digit CSD word and streams it MSD first.
// Flags illegal digit codes and adjacent nonzero digits at load time.
module csd_serializer #(
    parameter int W = 5,
    localparam int IDX_W = $clog2(W)
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*W-1:0]       in_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_d,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 err
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state;
    state_t                state_nx;
    logic [W-1:0][1:0]     word;
    logic [W-1:0][1:0]     clean;
    logic [IDX_W-1:0]      idx;
    logic                  bad;
    logic                  load;
    logic                  xfer;
    logic                  last;

    // Code 10 is replaced by zero before the adjacency scan
    always_comb begin
        clean = in_y;
        bad   = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (clean[i] == 2'b10) begin
                clean[i] = 2'b00;
                bad      = 1'b1;
            end
        end
        for (int i = 0; i < W - 1; i++) begin
            if (clean[i] != 2'b00 && clean[i+1] != 2'b00) begin
                bad = 1'b1;
            end
        end
    end

    assign out_valid = (state == SHIFT);
    assign last      = (idx == '0);
    assign out_last  = out_valid && last;
    assign out_first = out_valid && (idx == IDX_W'(W - 1));
    assign out_idx   = idx;
    assign out_d     = out_valid ? word[idx] : 2'b00;
    assign xfer      = out_valid && out_ready;
    assign in_ready  = (state == IDLE) || (xfer && last);
    assign load      = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer && last && !in_valid) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
            word  <= '0;
            idx   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= load && bad;
            if (load) begin
                word <= clean;
                idx  <= IDX_W'(W - 1);
            end else if (xfer) begin
                idx <= idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_csd_serializer.sv
// Directed bench for csd_serializer (W=5) with a digit scoreboard.
// Expected digits are queued on each accepted word and checked on output.
module tb_csd_serializer;

    localparam int W = 5;

    logic           clk = 1'b0;
    logic           arst;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] in_y;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_d;
    logic [2:0]     out_idx;
    logic           out_first;
    logic           out_last;
    logic           err;

    typedef struct packed {
        logic [1:0] d;
        logic [2:0] idx;
        logic       first;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic exp_err = 1'b0;

    csd_serializer #(.W(W)) dut (
        .clk       (clk),
        .arst      (arst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_idx   (out_idx),
        .out_first (out_first),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent model: sanitise codes, detect illegal/adjacent digits
    task automatic push_word(input logic [2*W-1:0] w, output logic bad);
        logic [1:0] d [W];
        exp_t       e;
        bad = 1'b0;
        for (int i = 0; i < W; i++) begin
            d[i] = {w[2*i+1], w[2*i]};
            if (d[i] == 2'b10) begin
                d[i] = 2'b00;
                bad  = 1'b1;
            end
        end
        for (int i = 0; i < W - 1; i++)
            if (d[i] != 2'b00 && d[i+1] != 2'b00) bad = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            e.d     = d[i];
            e.idx   = 3'(i);
            e.first = (i == W - 1);
            e.last  = (i == 0);
            sb.push_back(e);
        end
    endtask

    // Entered and left at a falling edge; inputs must already be set
    task automatic tick(output bit acc);
        exp_t e;
        logic bad;
        logic rdy;
        bad = 1'b0;
        #1;
        rdy = (sb.size() == 0) || (out_ready && sb.size() == 1);
        chk("out_valid", 16'(out_valid), 16'(sb.size() != 0));
        chk("in_ready", 16'(in_ready), 16'(rdy));
        chk("err", 16'(err), 16'(exp_err));
        if (sb.size() != 0) begin
            e = sb[0];
            chk("digit", 16'({out_d, out_idx, out_first, out_last}),
                16'(e));
            if (out_ready) void'(sb.pop_front());
        end
        acc = in_valid && rdy;
        if (acc) push_word(in_y, bad);
        @(posedge clk);
        exp_err = acc && bad;
        @(negedge clk);
    endtask

    task automatic offer(input logic [2*W-1:0] w);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_y     = w;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 20) begin
            tick(acc);
            n++;
        end
        chk("accept_timeout", 16'(acc), 16'd1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || exp_err) && n < 40) begin
            tick(acc);
            n++;
        end
        chk("drain_timeout", 16'(sb.size()), 16'd0);
    endtask

    task automatic check_reset_vals();
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_out_d", 16'(out_d), 16'd0);
        chk("rst_out_idx", 16'(out_idx), 16'd0);
        chk("rst_first", 16'(out_first), 16'd0);
        chk("rst_last", 16'(out_last), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
    endtask

    initial begin
        bit acc;
        arst      = 1'b1;
        in_valid  = 1'b0;
        in_y      = '0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        arst = 1'b0;
        #1;
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        @(negedge clk);

        // 7 = 8 - 1
        offer(10'b00_01_00_00_11);
        drain();

        // back-to-back words with in_valid held
        offer(10'b01_00_11_00_01);
        offer(10'b11_00_00_01_00);
        drain();

        // stall three cycles on digit index 2
        offer(10'b01_00_01_00_11);
        in_valid = 1'b0;
        tick(acc);
        tick(acc);
        out_ready = 1'b0;
        tick(acc);
        tick(acc);
        tick(acc);
        chk("frozen_idx", 16'(out_idx), 16'd2);
        out_ready = 1'b1;
        drain();

        // illegal code at digit 2
        offer(10'b00_00_10_00_01);
        drain();

        // adjacent nonzero digits 0 and 1
        offer(10'b00_00_00_01_01);
        drain();

        // reset mid-word at index 3
        offer(10'b01_00_11_00_01);
        in_valid = 1'b0;
        tick(acc);
        chk("pre_rst_idx", 16'(out_idx), 16'd3);
        arst = 1'b1;
        sb.delete();
        exp_err = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        arst = 1'b0;
        #1;
        chk("post_rst_in_ready", 16'(in_ready), 16'd1);
        chk("post_rst_valid", 16'(out_valid), 16'd0);
        @(negedge clk);
        offer(10'b11_00_01_00_11);
        drain();

        // assorted words, including illegal and adjacent patterns
        for (int k = 0; k < 8; k++) begin
            offer(10'($urandom));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
